sum_accumulator: RTL and testbench

//   Downstream consumer of the registered adder output. Accumulates a

---
 rtl/sum_accumulator.sv | 112 +++++++++++
 tb/tb_sum_accumulator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/sum_accumulator.sv
// ---------------------------------------------------------------------------
// sum_accumulator
//   Adds a programmable number of valid adder results into a wider unsigned
//   accumulator. The total is presented on a valid/ready handshake, along
//   with a sticky flag that records any carry out of the accumulator.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; acc/overflow keep the last run's values
//   S_ACCUM | adding valid samples until count reaches target
//   S_HOLD  | total presented (acc_valid=1) until acc_ready
//
// Ports
//   clk          clock, all state on rising edge
//   rstn         asynchronous active-low reset
//   start        begin a run (accepted only in IDLE)
//   num_samples  samples per run, sampled with start (0 = ignored)
//   in_valid     sum is a valid sample this cycle
//   sum          adder result, unsigned
//   busy         state != IDLE
//   acc_valid    acc holds a completed total
//   acc_ready    consumer accepts acc
//   acc          accumulated total, mod 2**ACC_WIDTH
//   overflow     sticky carry out of acc during the run
// ---------------------------------------------------------------------------
module sum_accumulator #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] num_samples,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     sum,
  output logic                 busy,
  output logic                 acc_valid,
  input  logic                 acc_ready,
  output logic [ACC_WIDTH-1:0] acc,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [ACC_WIDTH-1:0] r_acc;
  logic                 r_ovf;
  logic [CNT_WIDTH-1:0] r_target;
  logic [CNT_WIDTH-1:0] r_count;

  logic                 w_start_ok;
  logic                 w_take;
  logic                 w_last;
  logic [CNT_WIDTH-1:0] w_count_inc;
  logic [ACC_WIDTH:0]   w_add;

  assign w_start_ok  = (r_state == S_IDLE) && start && (num_samples != '0);
  assign w_take      = (r_state == S_ACCUM) && in_valid;
  assign w_count_inc = r_count + 1'b1;
  // count never exceeds target-1 before the increment, so no wrap here
  assign w_last      = w_take && (w_count_inc == r_target);
  // one extra bit captures the carry out of the accumulator
  assign w_add       = {1'b0, r_acc} + (ACC_WIDTH+1)'(sum);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_ACCUM;
      S_ACCUM: if (w_last)     w_next = S_HOLD;
      S_HOLD:  if (acc_ready)  w_next = S_IDLE;
      default:                 w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_target <= '0;
      r_count  <= '0;
    end else if (w_start_ok) begin
      r_acc    <= '0;
      r_ovf    <= 1'b0;
      r_target <= num_samples;
      r_count  <= '0;
    end else if (w_take) begin
      r_acc    <= w_add[ACC_WIDTH-1:0];
      r_ovf    <= r_ovf | w_add[ACC_WIDTH];
      r_count  <= w_count_inc;
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign acc_valid = (r_state == S_HOLD);
  assign acc       = r_acc;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_sum_accumulator.sv
// ---------------------------------------------------------------------------
// tb_sum_accumulator
//   Drives two accumulators (16-bit and 10-bit totals) with shared stimulus
//   and compares them to a reference that keeps the plain integer total of
//   the run's samples: acc = total mod 2**ACC_WIDTH, overflow = total
//   reached 2**ACC_WIDTH.
// ---------------------------------------------------------------------------
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [3:0]  num_samples;
  logic        in_valid;
  logic [7:0]  sum;
  logic        acc_ready;

  logic        busy_a, av_a, ov_a;
  logic [15:0] acc_a;
  logic        busy_b, av_b, ov_b;
  logic [9:0]  acc_b;

  int n_checks = 0;
  int n_errors = 0;
  int total;

  always #5 clk = ~clk;

  sum_accumulator #(.WIDTH(8), .ACC_WIDTH(16), .CNT_WIDTH(4)) u_dut_a (
    .clk(clk), .rstn(rstn), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .sum(sum), .busy(busy_a), .acc_valid(av_a),
    .acc_ready(acc_ready), .acc(acc_a), .overflow(ov_a)
  );

  sum_accumulator #(.WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(4)) u_dut_b (
    .clk(clk), .rstn(rstn), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .sum(sum), .busy(busy_b), .acc_valid(av_b),
    .acc_ready(acc_ready), .acc(acc_b), .overflow(ov_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic chk_all(input string tag, input bit exp_busy, input bit exp_av);
    chk({tag, " busy_a"}, 32'(busy_a), 32'(exp_busy));
    chk({tag, " av_a"},   32'(av_a),   32'(exp_av));
    chk({tag, " acc_a"},  32'(acc_a),  32'(total % 65536));
    chk({tag, " ov_a"},   32'(ov_a),   32'(total >= 65536));
    chk({tag, " busy_b"}, 32'(busy_b), 32'(exp_busy));
    chk({tag, " av_b"},   32'(av_b),   32'(exp_av));
    chk({tag, " acc_b"},  32'(acc_b),  32'(total % 1024));
    chk({tag, " ov_b"},   32'(ov_b),   32'(total >= 1024));
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    start = 1'b0; num_samples = '0; in_valid = 1'b0; sum = '0; acc_ready = 1'b0;
  endtask

  // One full run: smp[k] is preceded by gap[k] cycles with in_valid=0.
  task automatic do_run(input string tag, input int n, input int unsigned smp[$],
                        input int gap[$], input int hold_cycles);
    start = 1'b1; num_samples = 4'(n);
    step();
    total = 0;
    idle_inputs();
    chk_all({tag, " started"}, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < gap[k]; g++) begin
        in_valid = 1'b0; sum = 8'($urandom); start = 1'($urandom);
        acc_ready = 1'($urandom); num_samples = 4'($urandom);
        step();
        chk_all({tag, " gap"}, 1'b1, 1'b0);
      end
      in_valid = 1'b1; sum = 8'(smp[k]); start = 1'($urandom);
      acc_ready = 1'($urandom); num_samples = 4'($urandom);
      step();
      total += int'(smp[k]);
      chk_all({tag, " sample"}, 1'b1, (k == n - 1));
    end
    for (int h = 0; h < hold_cycles; h++) begin
      acc_ready = 1'b0; start = 1'($urandom); in_valid = 1'($urandom);
      sum = 8'($urandom); num_samples = 4'($urandom_range(1, 15));
      step();
      chk_all({tag, " hold"}, 1'b1, 1'b1);
    end
    // handshake cycle: start/in_valid must be ignored
    acc_ready = 1'b1; start = 1'b1; in_valid = 1'b1; sum = 8'hff; num_samples = 4'd3;
    step();
    chk_all({tag, " released"}, 1'b0, 1'b0);
    // in IDLE in_valid is ignored and the last total is kept
    idle_inputs();
    in_valid = 1'b1; sum = 8'($urandom_range(1, 255)); acc_ready = 1'($urandom);
    step();
    idle_inputs();
    chk_all({tag, " idle keep"}, 1'b0, 1'b0);
  endtask

  initial begin
    int unsigned smp[$];
    int          gap[$];
    int          n;

    idle_inputs();
    total = 0;
    rstn = 1'b0;
    step();
    step();
    chk_all("reset", 1'b0, 1'b0);
    rstn = 1'b1;
    step();
    chk_all("post reset", 1'b0, 1'b0);

    smp = '{25, 55};          gap = '{0, 0};
    do_run("two", 2, smp, gap, 0);
    smp = '{10, 20, 30};      gap = '{0, 2, 0};
    do_run("gaps", 3, smp, gap, 1);
    smp = '{255, 255, 255, 255, 255}; gap = '{0, 0, 0, 0, 0};
    do_run("ovf", 5, smp, gap, 3);

    // zero-sample start is ignored
    start = 1'b1; num_samples = 4'd0;
    step();
    chk_all("zero start", 1'b0, 1'b0);
    step();
    idle_inputs();
    chk_all("zero start2", 1'b0, 1'b0);

    // maximum-length run
    smp.delete(); gap.delete();
    for (int k = 0; k < 15; k++) begin smp.push_back(255); gap.push_back(0); end
    do_run("max", 15, smp, gap, 2);

    for (int r = 0; r < 25; r++) begin
      n = $urandom_range(1, 15);
      smp.delete(); gap.delete();
      for (int k = 0; k < n; k++) begin
        smp.push_back($urandom_range(0, 255));
        gap.push_back($urandom_range(0, 2));
      end
      do_run("rand", n, smp, gap, $urandom_range(0, 3));
    end

    // reset in the middle of ACCUM acts immediately
    start = 1'b1; num_samples = 4'd4;
    step();
    idle_inputs();
    in_valid = 1'b1; sum = 8'd100;
    step();
    step();
    #2;
    rstn = 1'b0;
    #1;
    total = 0;
    chk_all("async reset", 1'b0, 1'b0);
    step();
    rstn = 1'b1;
    step();
    chk_all("after reset", 1'b0, 1'b0);
    idle_inputs();
    smp = '{7, 9};            gap = '{1, 0};
    do_run("after rst run", 2, smp, gap, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
